// File: rtl/mem_txn_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_txn_fsm_if
// Brief    : Request, byte-stream and QSPI engine signals for mem_txn_fsm.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_txn_fsm_if;
    logic        ena;
    logic        r_w;
    logic        address_valid;
    logic [23:0] address;
    logic        length_valid;
    logic [8:0]  length;
    logic [7:0]  fsm_in_data;
    logic        fsm_in_valid;
    logic        fsm_ready;
    logic [7:0]  fsm_out_data;
    logic        fsm_out_valid;
    logic        fsm_out_ready;
    logic        txn_done;
    logic        qspi_frame;
    logic [7:0]  qspi_tx_data;
    logic        qspi_tx_valid;
    logic        qspi_tx_ready;
    logic [7:0]  qspi_rx_data;
    logic        qspi_rx_valid;
    logic        qspi_rx_ready;

    modport slave (
        input  ena, r_w, address_valid, address, length_valid, length,
        input  fsm_in_data, fsm_in_valid, fsm_out_ready,
        input  qspi_tx_ready, qspi_rx_data, qspi_rx_valid,
        output fsm_ready, fsm_out_data, fsm_out_valid, txn_done,
        output qspi_frame, qspi_tx_data, qspi_tx_valid, qspi_rx_ready
    );

    modport master (
        output ena, r_w, address_valid, address, length_valid, length,
        output fsm_in_data, fsm_in_valid, fsm_out_ready,
        output qspi_tx_ready, qspi_rx_data, qspi_rx_valid,
        input  fsm_ready, fsm_out_data, fsm_out_valid, txn_done,
        input  qspi_frame, qspi_tx_data, qspi_tx_valid, qspi_rx_ready
    );
endinterface
`default_nettype wire

// File: rtl/mem_txn_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mem_txn_fsm
// Brief    : Turns read/write requests into SPI-flash frames (WREN, opcode,
//            24-bit address, data) on a byte-level QSPI engine.
//            Define FAST_READ_EN for 0x0B reads with one dummy byte.
// Revision : 1.0 - initial release
// ============================================================================
module mem_txn_fsm #(
    parameter logic [7:0] RD_OPCODE   = 8'h03,
    parameter logic [7:0] WR_OPCODE   = 8'h02,
    parameter logic [7:0] WREN_OPCODE = 8'h06,
    parameter int         MAX_LEN     = 256
) (
    input  wire logic    clk,
    input  wire logic    rst,
    mem_txn_fsm_if.slave bus
);

    localparam logic [3:0] c_st_idle    = 4'd0;
    localparam logic [3:0] c_st_wren    = 4'd1;
    localparam logic [3:0] c_st_gap     = 4'd2;
    localparam logic [3:0] c_st_cmd     = 4'd3;
    localparam logic [3:0] c_st_addr    = 4'd4;
    localparam logic [3:0] c_st_data_rd = 4'd5;
    localparam logic [3:0] c_st_data_wr = 4'd6;
    localparam logic [3:0] c_st_done    = 4'd7;
`ifdef FAST_READ_EN
    localparam logic [3:0] c_st_dummy   = 4'd8;
    localparam logic [7:0] c_rd_opcode  = 8'h0B;
`else
    localparam logic [7:0] c_rd_opcode  = RD_OPCODE;
`endif
    localparam logic [9:0] c_max_len    = 10'(MAX_LEN);

    logic [3:0]  r_state;
    logic [3:0]  w_next_state;
    logic [23:0] r_addr;
    logic [8:0]  r_len;
    logic        r_addr_flag;
    logic        r_len_flag;
    logic        r_rd;
    logic [1:0]  r_idx;
    logic [8:0]  r_cnt;
    logic [7:0]  r_out_data;
    logic        r_out_valid;

    logic        w_frame;
    logic [7:0]  w_tx_data;
    logic        w_tx_valid;
    logic        w_fsm_ready;
    logic        w_rx_ready;
    logic [8:0]  w_len_sel;
    logic        w_req;
    logic        w_len_ok;
    logic        w_tx_fire;
    logic        w_rx_fire;
    logic        w_out_fire;

    // A qualifier arriving this cycle counts as already latched
    assign w_len_sel  = bus.length_valid ? bus.length : r_len;
    assign w_req      = (r_state == c_st_idle) && bus.ena &&
                        (r_addr_flag || bus.address_valid) &&
                        (r_len_flag  || bus.length_valid);
    assign w_len_ok   = (w_len_sel != 9'd0) && ({1'b0, w_len_sel} <= c_max_len);
    assign w_tx_fire  = w_tx_valid && bus.qspi_tx_ready;
    assign w_rx_fire  = bus.qspi_rx_valid && w_rx_ready;
    assign w_out_fire = r_out_valid && bus.fsm_out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_frame      = 1'b0;
        w_tx_data    = 8'h00;
        w_tx_valid   = 1'b0;
        w_fsm_ready  = 1'b0;
        w_rx_ready   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_req && w_len_ok) begin
                    w_next_state = bus.r_w ? c_st_cmd : c_st_wren;
                end
            end
            c_st_wren: begin
                w_frame    = 1'b1;
                w_tx_data  = WREN_OPCODE;
                w_tx_valid = 1'b1;
                if (bus.qspi_tx_ready) w_next_state = c_st_gap;
            end
            c_st_gap: begin
                w_next_state = c_st_cmd;
            end
            c_st_cmd: begin
                w_frame    = 1'b1;
                w_tx_data  = r_rd ? c_rd_opcode : WR_OPCODE;
                w_tx_valid = 1'b1;
                if (bus.qspi_tx_ready) w_next_state = c_st_addr;
            end
            c_st_addr: begin
                w_frame    = 1'b1;
                w_tx_valid = 1'b1;
                case (r_idx)
                    2'd0:    w_tx_data = r_addr[23:16];
                    2'd1:    w_tx_data = r_addr[15:8];
                    default: w_tx_data = r_addr[7:0];
                endcase
                if (bus.qspi_tx_ready && (r_idx == 2'd2)) begin
`ifdef FAST_READ_EN
                    w_next_state = r_rd ? c_st_dummy : c_st_data_wr;
`else
                    w_next_state = r_rd ? c_st_data_rd : c_st_data_wr;
`endif
                end
            end
`ifdef FAST_READ_EN
            c_st_dummy: begin
                w_frame    = 1'b1;
                w_tx_valid = 1'b1;
                if (bus.qspi_tx_ready) w_next_state = c_st_data_rd;
            end
`endif
            c_st_data_wr: begin
                w_frame     = 1'b1;
                w_tx_data   = bus.fsm_in_data;
                w_tx_valid  = bus.fsm_in_valid;
                w_fsm_ready = bus.qspi_tx_ready;
                if (bus.fsm_in_valid && bus.qspi_tx_ready && (r_cnt == 9'd1)) begin
                    w_next_state = c_st_done;
                end
            end
            c_st_data_rd: begin
                w_frame    = 1'b1;
                // One-deep output buffer: refill only when empty or draining
                w_rx_ready = !r_out_valid || bus.fsm_out_ready;
                if (w_out_fire && (r_cnt == 9'd1)) w_next_state = c_st_done;
            end
            c_st_done: begin
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= 24'd0;
            r_len       <= 9'd0;
            r_addr_flag <= 1'b0;
            r_len_flag  <= 1'b0;
            r_rd        <= 1'b0;
            r_idx       <= 2'd0;
            r_cnt       <= 9'd0;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
        end else begin
            if (r_state == c_st_idle) begin
                if (bus.address_valid) begin
                    r_addr      <= bus.address;
                    r_addr_flag <= 1'b1;
                end
                if (bus.length_valid) begin
                    r_len      <= bus.length;
                    r_len_flag <= 1'b1;
                end
                // Flags clear on every start attempt, including discarded ones
                if (w_req) begin
                    r_addr_flag <= 1'b0;
                    r_len_flag  <= 1'b0;
                    r_rd        <= bus.r_w;
                end
            end

            if (r_state == c_st_addr) begin
                if (w_tx_fire) r_idx <= r_idx + 2'd1;
            end else begin
                r_idx <= 2'd0;
            end

            if (r_state == c_st_data_wr) begin
                if (w_tx_fire) r_cnt <= r_cnt - 9'd1;
            end else if (r_state == c_st_data_rd) begin
                if (w_out_fire) r_cnt <= r_cnt - 9'd1;
            end else begin
                r_cnt <= r_len;
            end

            if (r_state == c_st_data_rd) begin
                if (w_rx_fire) begin
                    r_out_data  <= bus.qspi_rx_data;
                    r_out_valid <= 1'b1;
                end else if (w_out_fire) begin
                    r_out_valid <= 1'b0;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.txn_done      = (r_state == c_st_idle);
    assign bus.qspi_frame    = w_frame;
    assign bus.qspi_tx_data  = w_tx_data;
    assign bus.qspi_tx_valid = w_tx_valid;
    assign bus.qspi_rx_ready = w_rx_ready;
    assign bus.fsm_ready     = w_fsm_ready;
    assign bus.fsm_out_data  = r_out_data;
    assign bus.fsm_out_valid = r_out_valid;

endmodule
`default_nettype wire
